// File: rtl/logic_gate_demo_multi.sv
// Synchronised, debounced switches feed a button-selected N-input reduction gate.
// Define LOGIC_GATE_DEMO_AUTOSTEP_EN to add a timed mode autostep.
module logic_gate_demo_multi #(
   parameter int N_INPUTS        = 2,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int AUTOSTEP_CYCLES = 200000000
) (
   input  logic                I_P_CLK,
   input  logic                I_P_RST_N,
   input  logic [N_INPUTS-1:0] I_P_SW,
   input  logic                I_P_BTN_MODE,
   output logic [N_INPUTS-1:0] O_P_LED_IN,
   output logic                O_P_LED_GATE,
   output logic [2:0]          O_P_LED_MODE,
   output logic                O_P_MODE_CHANGE
);

   typedef enum logic [2:0] {
      MODE_AND  = 3'd0,
      MODE_OR   = 3'd1,
      MODE_NAND = 3'd2,
      MODE_NOR  = 3'd3,
      MODE_XOR  = 3'd4,
      MODE_XNOR = 3'd5
   } mode_e;

   // Switch bits and the button share one synchroniser/debouncer vector; button is the MSB.
   localparam int NB = N_INPUTS + 1;
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES);

   if (N_INPUTS < 2 || N_INPUTS > 8 || DEBOUNCE_CYCLES < 2 || AUTOSTEP_CYCLES < 2) begin : g_param_check
      $error("logic_gate_demo_multi: parameter out of range");
   end

   logic [NB-1:0] w_raw;
   logic [NB-1:0] r_sync1;
   logic [NB-1:0] r_sync2;
   logic [NB-1:0] r_deb;
   logic [CW-1:0] r_cnt [NB];
   logic [NB-1:0] w_commit;
   logic          w_btn_rise;
   logic          w_advance;
   mode_e         r_mode;
   logic          r_mode_change;
   logic          w_gate;
   logic          r_gate;
   logic [N_INPUTS-1:0] w_sw;

   assign w_raw = {I_P_BTN_MODE, I_P_SW};

   // A bit commits once DEBOUNCE_CYCLES differing edges are already counted and it still differs.
   always_comb begin
      // NOTE: default every always_comb output first so no path can infer a latch.
      w_commit = '0;
      for (int i = 0; i < NB; i++) begin
         w_commit[i] = (r_sync2[i] != r_deb[i]) && (r_cnt[i] == CNT_LAST);
      end
   end

   always_ff @(posedge I_P_CLK or negedge I_P_RST_N) begin
      if (!I_P_RST_N) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_deb   <= '0;
         // NOTE: the counter array is reset too, so no partial count survives a reset.
         for (int i = 0; i < NB; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments keep the two synchroniser stages as separate flops.
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         for (int i = 0; i < NB; i++) begin
            if (r_sync2[i] == r_deb[i]) begin
               r_cnt[i] <= '0;
            end else if (w_commit[i]) begin
               r_deb[i] <= r_sync2[i];
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CW'(1);
            end
         end
      end
   end

   // Advance on the same edge the debounced button rises, so mode and LED_IN stay aligned.
   assign w_btn_rise = w_commit[NB-1] & r_sync2[NB-1];

`ifdef LOGIC_GATE_DEMO_AUTOSTEP_EN
   localparam int AW = $clog2(AUTOSTEP_CYCLES);
   localparam logic [AW-1:0] AUTO_LAST = AW'(AUTOSTEP_CYCLES - 1);

   logic [AW-1:0] r_auto_cnt;
   logic          w_auto_tc;

   assign w_auto_tc = (r_auto_cnt == AUTO_LAST);
   assign w_advance = w_btn_rise | w_auto_tc;

   always_ff @(posedge I_P_CLK or negedge I_P_RST_N) begin
      if (!I_P_RST_N) begin
         r_auto_cnt <= '0;
      end else if (w_advance) begin
         r_auto_cnt <= '0;
      end else begin
         r_auto_cnt <= r_auto_cnt + AW'(1);
      end
   end
`else
   assign w_advance = w_btn_rise;
`endif

   always_ff @(posedge I_P_CLK or negedge I_P_RST_N) begin
      if (!I_P_RST_N) begin
         r_mode        <= MODE_NAND;
         r_mode_change <= 1'b0;
      end else begin
         r_mode_change <= 1'b0;
         if (r_mode > MODE_XNOR) begin
            r_mode <= MODE_AND;
         end else if (w_advance) begin
            r_mode        <= (r_mode == MODE_XNOR) ? MODE_AND : mode_e'(r_mode + 3'd1);
            r_mode_change <= 1'b1;
         end
      end
   end

   assign w_sw = r_deb[N_INPUTS-1:0];

   always_comb begin
      w_gate = 1'b0;
      case (r_mode)
         MODE_AND:  w_gate = &w_sw;
         MODE_OR:   w_gate = |w_sw;
         MODE_NAND: w_gate = ~&w_sw;
         MODE_NOR:  w_gate = ~|w_sw;
         MODE_XOR:  w_gate = ^w_sw;
         MODE_XNOR: w_gate = ~^w_sw;
         default:   w_gate = 1'b0;
      endcase
   end

   always_ff @(posedge I_P_CLK or negedge I_P_RST_N) begin
      if (!I_P_RST_N) begin
         r_gate <= 1'b1;
      end else begin
         r_gate <= w_gate;
      end
   end

   assign O_P_LED_IN      = w_sw;
   assign O_P_LED_GATE    = r_gate;
   assign O_P_LED_MODE    = r_mode;
   assign O_P_MODE_CHANGE = r_mode_change;

endmodule

// File: tb/tb_logic_gate_demo_multi.sv
// Scoreboard bench for logic_gate_demo_multi with N_INPUTS=3, DEBOUNCE_CYCLES=4, AUTOSTEP_CYCLES=20.
module tb_logic_gate_demo_multi;

   localparam int N = 3;
   localparam int D = 4;
   localparam int A = 20;
   localparam int LAT = D + 3;   // drive-to-update ticks: sampling edge plus D+2 edges
`ifdef LOGIC_GATE_DEMO_AUTOSTEP_EN
   localparam int RESET_HOLD = A - 1;
`else
   localparam int RESET_HOLD = 20;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] sw;
   logic         btn;
   logic [N-1:0] led_in;
   logic         led_gate;
   logic [2:0]   led_mode;
   logic         mode_change;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [2:0] mode;
      logic       gate;
   } exp_t;

   exp_t         sb_q[$];
   logic [2:0]   exp_mode;
   logic [N-1:0] exp_in;

   always #5 clk = ~clk;

   logic_gate_demo_multi #(
      .N_INPUTS        (N),
      .DEBOUNCE_CYCLES (D),
      .AUTOSTEP_CYCLES (A)
   ) dut (
      .I_P_CLK         (clk),
      .I_P_RST_N       (rst_n),
      .I_P_SW          (sw),
      .I_P_BTN_MODE    (btn),
      .O_P_LED_IN      (led_in),
      .O_P_LED_GATE    (led_gate),
      .O_P_LED_MODE    (led_mode),
      .O_P_MODE_CHANGE (mode_change)
   );

   function automatic logic gate_model(input logic [2:0] m, input logic [N-1:0] v);
      case (m)
         3'd0:    return &v;
         3'd1:    return |v;
         3'd2:    return ~&v;
         3'd3:    return ~|v;
         3'd4:    return ^v;
         3'd5:    return ~^v;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] next_mode(input logic [2:0] m);
      return (m == 3'd5) ? 3'd0 : 3'(m + 3'd1);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_pulse(input int max_cycles, output int n, output bit ok);
      ok = 1'b0;
      n  = 0;
      while (!ok && n < max_cycles) begin
         tick();
         n++;
         if (mode_change === 1'b1) ok = 1'b1;
      end
   endtask

   // One button press: push the expected result, wait for the pulse, pop and compare.
   task automatic press(input string tag, input int hold);
      int   n;
      bit   ok;
      int   extra;
      exp_t e;
      exp_mode = next_mode(exp_mode);
      sb_q.push_back('{mode: exp_mode, gate: gate_model(exp_mode, exp_in)});
      btn = 1'b1;
      wait_pulse(3 * LAT, n, ok);
      e = sb_q.pop_front();
      checks++;
      if (!ok || n != LAT) begin
         failures++;
         $display("FAIL %s latency: got %0d ticks (seen=%0b) want %0d", tag, n, ok, LAT);
      end
      checks++;
      if (led_mode !== e.mode) begin
         failures++;
         $display("FAIL %s mode: got %0d want %0d", tag, led_mode, e.mode);
      end
      tick();
      checks++;
      if (mode_change !== 1'b0) begin
         failures++;
         $display("FAIL %s pulse_width: mode_change got %b want 0", tag, mode_change);
      end
      checks++;
      if (led_gate !== e.gate) begin
         failures++;
         $display("FAIL %s gate: got %b want %b", tag, led_gate, e.gate);
      end
      extra = 0;
      for (int i = 0; i < hold; i++) begin
         tick();
         if (mode_change === 1'b1) extra++;
      end
      btn = 1'b0;
      for (int i = 0; i < 3 * LAT; i++) begin
         tick();
         if (mode_change === 1'b1) extra++;
      end
      checks++;
      if (extra != 0 || led_mode !== e.mode) begin
         failures++;
         $display("FAIL %s repeat: extra pulses %0d mode %0d want 0 pulses mode %0d", tag, extra, led_mode, e.mode);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      checks++;
      if (led_in !== '0 || led_mode !== 3'd2 || led_gate !== 1'b1 || mode_change !== 1'b0) begin
         failures++;
         $display("FAIL %s: in=%b mode=%0d gate=%b chg=%b want in=000 mode=2 gate=1 chg=0",
                  tag, led_in, led_mode, led_gate, mode_change);
      end
   endtask

   task automatic test_reset();
      sw    = '0;
      btn   = 1'b0;
      rst_n = 1'b1;
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1 check_reset_vals("reset_immediate");
      tick();
      tick();
      rst_n    = 1'b1;
      exp_mode = 3'd2;
      exp_in   = '0;
      for (int i = 0; i < RESET_HOLD; i++) begin
         tick();
         check_reset_vals("reset_hold");
      end
   endtask

   task automatic test_debounce();
      sw = 3'b111;
      for (int k = 1; k <= LAT + 1; k++) begin
         tick();
         checks++;
         if (led_in !== ((k >= LAT) ? 3'b111 : 3'b000)) begin
            failures++;
            $display("FAIL deb_latency tick %0d: led_in got %b want %b", k, led_in, (k >= LAT) ? 3'b111 : 3'b000);
         end
         checks++;
         if (led_gate !== ((k >= LAT + 1) ? 1'b0 : 1'b1)) begin
            failures++;
            $display("FAIL deb_gate tick %0d: got %b want %b", k, led_gate, (k >= LAT + 1) ? 1'b0 : 1'b1);
         end
      end
      exp_in = 3'b111;
      sw = 3'b001;
      for (int i = 0; i < D - 1; i++) tick();
      sw = 3'b111;
      for (int i = 0; i < 3 * LAT; i++) begin
         tick();
         checks++;
         if (led_in !== 3'b111 || led_gate !== 1'b0) begin
            failures++;
            $display("FAIL glitch tick %0d: in=%b gate=%b want in=111 gate=0", i, led_in, led_gate);
         end
      end
   endtask

   task automatic test_mode_step();
      sw = 3'b101;
      for (int i = 0; i < 2 * LAT; i++) tick();
      exp_in = 3'b101;
      checks++;
      if (led_in !== 3'b101 || led_gate !== gate_model(exp_mode, exp_in)) begin
         failures++;
         $display("FAIL step_setup: in=%b gate=%b want in=101 gate=%b", led_in, led_gate, gate_model(exp_mode, exp_in));
      end
      for (int p = 0; p < 6; p++) press($sformatf("step%0d", p), 3);
      press("step_held", 50);
   endtask

   task automatic test_simultaneous();
      int   n;
      exp_t e;
      sw = 3'b000;
      for (int i = 0; i < 2 * LAT; i++) tick();
      exp_in = 3'b000;
      sw  = 3'b011;
      btn = 1'b1;
      exp_mode = next_mode(exp_mode);
      sb_q.push_back('{mode: exp_mode, gate: gate_model(exp_mode, 3'b011)});
      for (n = 1; n < LAT; n++) begin
         tick();
         checks++;
         if (led_mode !== 3'd3 || led_in !== 3'b000 || led_gate !== 1'b1 || mode_change !== 1'b0) begin
            failures++;
            $display("FAIL simul_pre tick %0d: mode=%0d in=%b gate=%b chg=%b want 3 000 1 0",
                     n, led_mode, led_in, led_gate, mode_change);
         end
      end
      tick();
      e = sb_q.pop_front();
      checks++;
      if (led_mode !== e.mode || led_in !== 3'b011 || mode_change !== 1'b1 || led_gate !== 1'b1) begin
         failures++;
         $display("FAIL simul_edge: mode=%0d in=%b chg=%b gate=%b want %0d 011 1 1",
                  led_mode, led_in, mode_change, led_gate, e.mode);
      end
      tick();
      checks++;
      if (led_gate !== e.gate || mode_change !== 1'b0) begin
         failures++;
         $display("FAIL simul_gate: gate=%b chg=%b want %b 0", led_gate, mode_change, e.gate);
      end
      exp_in = 3'b011;
      btn = 1'b0;
      for (int i = 0; i < 3 * LAT; i++) tick();
   endtask

   task automatic test_reset_mid();
      press("to_mode5", 3);
      sw = 3'b010;
      for (int i = 0; i < 4; i++) tick();
      #2 rst_n = 1'b0;
      #1 check_reset_vals("reset_mid_immediate");
      tick();
      tick();
      rst_n    = 1'b1;
      exp_mode = 3'd2;
      for (int k = 1; k <= LAT + 1; k++) begin
         tick();
         checks++;
         if (led_in !== ((k >= LAT) ? 3'b010 : 3'b000) || led_mode !== 3'd2 || led_gate !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_redeb tick %0d: in=%b mode=%0d gate=%b want in=%b mode=2 gate=1",
                     k, led_in, led_mode, led_gate, (k >= LAT) ? 3'b010 : 3'b000);
         end
      end
      exp_in = 3'b010;
   endtask

`ifdef LOGIC_GATE_DEMO_AUTOSTEP_EN
   task automatic test_autostep();
      int n;
      bit ok;
      exp_t e;
      exp_mode = next_mode(exp_mode);
      sb_q.push_back('{mode: exp_mode, gate: gate_model(exp_mode, exp_in)});
      wait_pulse(2 * A, n, ok);
      e = sb_q.pop_front();
      checks++;
      if (!ok || n != 1 || led_mode !== e.mode) begin
         failures++;
         $display("FAIL auto_first: ticks=%0d seen=%0b mode=%0d want 1 tick mode %0d", n, ok, led_mode, e.mode);
      end
      for (int i = 0; i < 9; i++) tick();
      exp_mode = next_mode(exp_mode);
      sb_q.push_back('{mode: exp_mode, gate: gate_model(exp_mode, exp_in)});
      btn = 1'b1;
      wait_pulse(2 * A, n, ok);
      e = sb_q.pop_front();
      checks++;
      if (!ok || n != LAT || led_mode !== e.mode) begin
         failures++;
         $display("FAIL auto_button: ticks=%0d seen=%0b mode=%0d want %0d mode %0d", n, ok, led_mode, LAT, e.mode);
      end
      btn = 1'b0;
      exp_mode = next_mode(exp_mode);
      sb_q.push_back('{mode: exp_mode, gate: gate_model(exp_mode, exp_in)});
      wait_pulse(2 * A, n, ok);
      e = sb_q.pop_front();
      checks++;
      if (!ok || n != A || led_mode !== e.mode) begin
         failures++;
         $display("FAIL auto_restart: ticks=%0d seen=%0b mode=%0d want %0d mode %0d", n, ok, led_mode, A, e.mode);
      end
   endtask
`else
   task automatic test_no_autostep();
      for (int i = 0; i < 100; i++) begin
         tick();
         checks++;
         if (led_mode !== 3'd2 || mode_change !== 1'b0) begin
            failures++;
            $display("FAIL no_autostep tick %0d: mode=%0d chg=%b want 2 0", i, led_mode, mode_change);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
`ifdef LOGIC_GATE_DEMO_AUTOSTEP_EN
      test_autostep();
`else
      test_debounce();
      test_mode_step();
      test_simultaneous();
      test_reset_mid();
      test_no_autostep();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
